// File: rtl/sigmoid_pkg.sv
// Shared types and constants for the sigmoid datapath and its result buffer.
package sigmoid_pkg;

    localparam int BF16_W           = 16;
    localparam int SIGMOID_PIPE_LAT = 5;

    typedef logic [15:0] bf16_t;

endpackage : sigmoid_pkg

// File: rtl/sigmoid_fifo_mem.sv
// Result storage: one synchronous write port, one asynchronous read port so the
// head entry can be presented first-word-fall-through.
module sigmoid_fifo_mem
    import sigmoid_pkg::*;
#(
    parameter  int DATA_W = BF16_W,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : sigmoid_fifo_mem

// File: rtl/sigmoid_result_fifo.sv
// Credit-managed output buffer behind sigmoid_pipelined: captures every result,
// re-exports it on ready/valid, and hands issue credits back to the source.
module sigmoid_result_fifo
    import sigmoid_pkg::*;
#(
    parameter  int DATA_W = BF16_W,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    output logic              issue_ok,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  credits,
    output logic              overflow,
    output logic              underflow
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              empty;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic [CNT_W:0]    committed;
    logic [CNT_W-1:0]  credits_c;
    logic [DATA_W-1:0] head_data;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign pop     = ~empty & m_ready;
    // A full buffer can still take a result when the head leaves on the same edge.
    assign push_ok = res_valid & (~full | pop);

    // After an unsanctioned issue count+inflight may exceed DEPTH; clamp to zero credits.
    assign committed = {1'b0, count_q} + {1'b0, inflight_q};
    assign credits_c = (committed >= {1'b0, DEPTH_C}) ? '0
                     : DEPTH_C - count_q - inflight_q;

    assign issue_ok  = rst_n & (credits_c != '0);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, res_valid})
            2'b10: begin
                if (inflight_q != DEPTH_C) begin
                    inflight_d = inflight_q + CNT_ONE;
                end
            end
            2'b01: begin
                if (inflight_q != '0) begin
                    inflight_d = inflight_q - CNT_ONE;
                end
            end
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        wr_ptr_d    = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        overflow_d  = overflow_q | (issue & ~issue_ok) | (res_valid & ~push_ok);
        underflow_d = underflow_q | (res_valid & (inflight_q == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            inflight_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sigmoid_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q),
        .wdata (res_data),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    // Storage is never reset, so mask the head while empty to keep m_data clean.
    assign m_valid   = ~empty;
    assign m_data    = empty ? '0 : head_data;
    assign count     = count_q;
    assign credits   = credits_c;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule : sigmoid_result_fifo

// File: tb/tb_sigmoid_result_fifo.sv
// Randomised scoreboard bench for sigmoid_result_fifo behind a modelled 5-cycle pipeline.
module tb_sigmoid_result_fifo;
    import sigmoid_pkg::*;

    localparam int DEPTH = 8;
    localparam int LAT   = SIGMOID_PIPE_LAT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue;
    logic        issue_ok;
    logic        res_valid;
    logic [15:0] res_data;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic [3:0]  count;
    logic [3:0]  credits;
    logic        overflow;
    logic        underflow;

    sigmoid_result_fifo #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue),
        .issue_ok  (issue_ok),
        .res_valid (res_valid),
        .res_data  (res_data),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .count     (count),
        .credits   (credits),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Upstream pipeline model: each issue comes back LAT edges later.
    typedef struct {
        int unsigned at;
        logic [15:0] d;
    } pend_t;
    pend_t       sched[$];
    int unsigned edge_n = 0;

    // Reference model: a plain queue of stored results plus in-flight count.
    logic [15:0] exp_q[$];
    int          infl = 0;
    bit          ovf  = 1'b0;
    bit          udf  = 1'b0;

    always @(negedge clk) begin
        int  ec;
        int  pre;
        int  nxt;
        bit  pop_now;
        logic [15:0] hd;
        if (!rst_n) begin
            exp_q.delete();
            infl = 0;
            ovf  = 1'b0;
            udf  = 1'b0;
            chk("rst_m_valid", int'(m_valid), 0);
            chk("rst_m_data", int'(m_data), 0);
            chk("rst_count", int'(count), 0);
            chk("rst_credits", int'(credits), DEPTH);
            chk("rst_issue_ok", int'(issue_ok), 0);
            chk("rst_overflow", int'(overflow), 0);
            chk("rst_underflow", int'(underflow), 0);
        end else begin
            pre = exp_q.size();
            ec  = (pre + infl >= DEPTH) ? 0 : DEPTH - pre - infl;
            chk("count", int'(count), pre);
            chk("credits", int'(credits), ec);
            chk("issue_ok", int'(issue_ok), (ec != 0) ? 1 : 0);
            chk("m_valid", int'(m_valid), (pre != 0) ? 1 : 0);
            chk("overflow", int'(overflow), int'(ovf));
            chk("underflow", int'(underflow), int'(udf));
            pop_now = (pre != 0) && m_ready;
            if (pre != 0) chk("m_data", int'(m_data), int'(exp_q[0]));
            if (pop_now) begin
                hd = exp_q.pop_front();
                n_pop++;
                $display("pop %0d data=%h expected=%h", n_pop, m_data, hd);
            end
            if (res_valid) begin
                if (pre < DEPTH || pop_now) exp_q.push_back(res_data);
                else ovf = 1'b1;
                if (infl == 0) udf = 1'b1;
            end
            if (issue && ec == 0) ovf = 1'b1;
            nxt = infl + int'(issue) - int'(res_valid);
            if (nxt < 0) nxt = 0;
            if (nxt > DEPTH) nxt = DEPTH;
            infl = nxt;
        end
    end

    task automatic drive(input bit iss, input bit rdy, input logic [15:0] d, input bit force_rv);
        pend_t p;
        issue     = iss;
        m_ready   = rdy;
        res_valid = 1'b0;
        res_data  = 16'($urandom);
        if (sched.size() != 0 && sched[0].at == edge_n) begin
            p         = sched.pop_front();
            res_valid = 1'b1;
            res_data  = p.d;
        end else if (force_rv) begin
            res_valid = 1'b1;
            res_data  = d;
        end
        if (iss) begin
            p.at = edge_n + LAT;
            p.d  = d;
            sched.push_back(p);
        end
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic hold_reset(input int n);
        rst_n     = 1'b0;
        issue     = 1'b0;
        res_valid = 1'b0;
        m_ready   = 1'b0;
        sched.delete();
        #1;
        chk("rst_now_m_valid", int'(m_valid), 0);
        chk("rst_now_count", int'(count), 0);
        chk("rst_now_credits", int'(credits), DEPTH);
        chk("rst_now_issue_ok", int'(issue_ok), 0);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_n++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int c0;
        rst_n     = 1'b0;
        issue     = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        m_ready   = 1'b0;

        // Reset and release.
        hold_reset(3);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("issue_ok_after_release", int'(issue_ok), 1);

        // Fill with 8 back-to-back issues, consumer stalled.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 16'h3F00 + 16'(i), 1'b0);
        chk("fill_credits_zero", int'(credits), 0);
        chk("fill_issue_ok_low", int'(issue_ok), 0);
        repeat (6) drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("fill_count", int'(count), DEPTH);
        chk("fill_overflow", int'(overflow), 0);

        // Drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_head", int'(m_data), 16'h3F00 + i);
            drive(1'b0, 1'b1, 16'h0, 1'b0);
            chk("drain_credits", int'(credits), i + 1);
        end
        repeat (2) drive(1'b0, 1'b1, 16'h0, 1'b0);

        // Steady state: issue, push and pop every cycle.
        c0 = 0;
        for (int i = 0; i < 50; i++) begin
            chk("steady_issue_ok", int'(issue_ok), 1);
            drive(1'b1, 1'b1, 16'($urandom), 1'b0);
            if (i == 10) c0 = int'(credits);
            if (i > 10) chk("steady_credits_const", int'(credits), c0);
        end
        repeat (10) drive(1'b0, 1'b1, 16'h0, 1'b0);

        // Legal random traffic.
        for (int i = 0; i < 300; i++)
            drive(issue_ok && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  16'($urandom), 1'b0);
        repeat (12) drive(1'b0, 1'b1, 16'h0, 1'b0);
        chk("legal_no_overflow", int'(overflow), 0);
        chk("legal_no_underflow", int'(underflow), 0);

        // Issue without credit.
        repeat (10) drive(1'b1, 1'b0, 16'($urandom), 1'b0);
        chk("overflow_set", int'(overflow), 1);
        repeat (20) drive(1'b0, 1'b1, 16'h0, 1'b0);
        chk("overflow_sticky", int'(overflow), 1);

        // Result with nothing in flight.
        drive(1'b0, 1'b1, 16'hBEEF, 1'b1);
        chk("underflow_set", int'(underflow), 1);
        repeat (3) drive(1'b0, 1'b1, 16'h0, 1'b0);
        chk("underflow_sticky", int'(underflow), 1);

        // Random traffic with protocol errors allowed.
        for (int i = 0; i < 150; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                  $urandom_range(0, 7) == 0);
        hold_reset(2);
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("flags_clear_ovf", int'(overflow), 0);
        chk("flags_clear_udf", int'(underflow), 0);

        // Reset with count=4 and inflight=3.
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 16'h4000 + 16'(i), 1'b0);
        repeat (2) drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("mid_count_before", int'(count), 4);
        chk("mid_credits_before", int'(credits), 1);
        hold_reset(2);
        repeat (12) begin
            drive(1'b0, 1'b1, 16'h0, 1'b0);
            chk("mid_no_stale", int'(m_valid), 0);
        end
        chk("mid_count_after", int'(count), 0);
        chk("mid_credits_after", int'(credits), DEPTH);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sigmoid_result_fifo

// File: doc/sigmoid_result_fifo.md
# sigmoid_result_fifo

Credit-managed output buffer that sits directly downstream of `sigmoid_pipelined`. It captures every bf16 result presented on the pipeline's `valid_out`/`data_out` and re-exports it on a ready/valid stream. It also returns an `issue_ok` credit to the upstream source, because `sigmoid_pipelined` has no stall input and a result must never arrive at a full buffer.

## Interface
- `DATA_W`, 16: result width (bf16).
- `DEPTH`, 8: buffer entries; power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH+1)`: width of occupancy and credit counters (derived; not overridden).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue`  in  1  upstream drove `valid_in` into `sigmoid_pipelined` this cycle.
- `issue_ok`  out  1  a credit is available; upstream may assert `issue` this cycle.
- `res_valid`  in  1  `sigmoid_pipelined.valid_out`.
- `res_data`  in  DATA_W  `sigmoid_pipelined.data_out`.
- `m_valid`  out  1  head entry valid.
- `m_data`  out  DATA_W  head entry (first-word fall-through).
- `m_ready`  in  1  consumer accepts head.
- `count`  out  CNT_W  entries currently stored.
- `credits`  out  CNT_W  `DEPTH − count − inflight`.
- `overflow`  out  1  sticky error: `issue` without credit, or push to full.
- `underflow`  out  1  sticky error: `res_valid` with `inflight == 0`.

## Operation
- Registers:
  - `inflight`: issued but not yet returned; 0..DEPTH.
  - `count`: 0..DEPTH.
  - `wr_ptr`/`rd_ptr`: log2(DEPTH) bits; wrap modulo DEPTH.
  - sticky flags `overflow` and `underflow`.
- Push = `res_valid`; pop = `m_valid & m_ready`.
- `inflight_next = inflight + issue − res_valid`.
  - Saturates at 0 on underflow; `underflow` set.
  - Saturates at DEPTH on overflow.
- `count_next = count + push_accepted − pop`.
  - A push is accepted when `count < DEPTH` or a pop occurs in the same cycle.
  - Otherwise the data is dropped and `overflow` is set.
- `credits` is combinational from registered `count`/`inflight`.
- `issue_ok = rst_n & (credits != 0)`.
  - `issue` while `issue_ok == 0` sets `overflow`.
  - The issue is still counted in `inflight` (saturating).
- Simultaneous issue, push and pop in one cycle: each counter applies all deltas, so the net credit change is `+pop − issue`.
- A pop returns its credit on the next cycle. A push does not change credits; the credit was consumed at issue.
- `m_valid = (count != 0)`; `m_data = mem[rd_ptr]`. The head holds stable while `m_valid & ~m_ready`.
- Sticky flags clear only on reset.
- Reset mid-operation:
  - Pointers, counters and flags clear immediately.
  - Results still in flight inside `sigmoid_pipelined` arrive with `inflight == 0` and set `underflow`.
  - Upstream must reset the pipeline together with this block.

## Timing
- Reset values:
  - `m_valid=0`, `m_data=0`, `count=0`, `overflow=0`, `underflow=0`.
  - `credits=DEPTH`.
  - `issue_ok=0` while `rst_n` is low; `issue_ok=1` from the first edge after release.
- Push-to-output latency: `res_valid` at edge N gives `m_valid=1` after edge N (visible cycle N+1). No combinational path from `res_*` to `m_*`.
- Pop-to-credit latency: 1 cycle.
- No combinational path from `m_ready` to `issue_ok`; `m_ready` affects `issue_ok` only through `count`.
- Full throughput: one push and one pop per cycle sustained when `DEPTH` ≥ pipeline latency + 1.
- Memory needs no reset; only the pointer/valid state is reset.

## Structure
- `sigmoid_pkg` holds:
  - `typedef logic [15:0] bf16_t`
  - `BF16_W = 16`
  - `SIGMOID_PIPE_LAT = 5`, used by benches to size `DEPTH`.
- One sub-module, `sigmoid_fifo_mem`: DEPTH×DATA_W storage with write port (`we`, `waddr`, `wdata`) and asynchronous read port (`raddr`, `rdata`).
- Counters, pointers and flags live in the top module.

## Test plan
- Reset: hold `rst_n=0` 3 cycles, then release. Required:
  - `m_valid=0`, `count=0`, `credits=8`.
  - `issue_ok=0` during reset, 1 on the first cycle after release.
- Fill: DEPTH=8, `m_ready=0`, issue 8 back-to-back. Required:
  - `credits` 8→0 and `issue_ok=0` the cycle after the 8th issue.
  - Results 0x3F00..0x3F07 returned 5 cycles later give `count=8`, `overflow=0`.
- Drain order: `m_ready=1` after fill. Required:
  - `m_data` yields 0x3F00..0x3F07 in order, one per cycle.
  - `credits` rises by 1 each cycle after each pop.
- Simultaneous events: steady state with issue, push and pop every cycle for 50 cycles. Required:
  - `credits` and `count` stay constant.
  - Output sequence equals input sequence; pointers wrap correctly past index 7.
- Errors:
  - `issue` while `issue_ok=0` → `overflow=1`, which persists.
  - `res_valid` with `inflight=0` → `underflow=1`.
  - Both flags clear only on `rst_n=0`.
- Reset mid-stream: assert `rst_n=0` with `count=4`, `inflight=3`. Required:
  - Immediately: `m_valid=0`, `count=0`, `credits=8`.
  - No stale data appears after release.
